// File: rtl/hps_cmd_sequencer_pkg.sv
// Shared types for the HPS command sequencer: opcodes, FSM states and default widths.
package hps_cmd_pkg;

  localparam int DEF_ADDR_W         = 17;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_MEM_DEPTH      = 76800;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1048576;
  localparam int OPCODE_W           = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP   = 3'd0,
    OP_WRITE = 3'd1,
    OP_READ  = 3'd2,
    OP_FILL  = 3'd3,
    OP_ALGO0 = 3'd4,
    OP_ALGO1 = 3'd5,
    OP_ALGO2 = 3'd6,
    OP_ALGO3 = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WRITE,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_FILL,
    ST_ALGO_START,
    ST_ALGO_WAIT,
    ST_DONE
  } state_e;

  // Opcodes whose address operand must be range-checked against the frame memory.
  function automatic logic is_mem_op(opcode_e op);
    return (op == OP_WRITE) || (op == OP_READ) || (op == OP_FILL);
  endfunction

endpackage

// File: rtl/hps_cmd_sequencer_if.sv
// PIO command/status, frame-memory and engine signals of the HPS command sequencer.
interface hps_cmd_sequencer_if
  import hps_cmd_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [OPCODE_W-1:0] pio_instruction;
  logic [DATA_W-1:0]   pio_data;
  logic [ADDR_W-1:0]   pio_mem_addr;
  logic                pio_sel_mem;
  logic                pio_enable;
  logic                mem_sel;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rdata;
  logic                algo_start;
  logic [1:0]          algo_op;
  logic                algo_done;
  logic                stat_busy;
  logic                stat_done;
  logic                stat_error;
  logic [DATA_W-1:0]   stat_rdata;

  // master = HPS + memory + engine side, slave = sequencer
  modport master (
    output pio_instruction, pio_data, pio_mem_addr, pio_sel_mem, pio_enable,
    output mem_rdata, algo_done,
    input  mem_sel, mem_addr, mem_wdata, mem_we, algo_start, algo_op,
    input  stat_busy, stat_done, stat_error, stat_rdata
  );

  modport slave (
    input  pio_instruction, pio_data, pio_mem_addr, pio_sel_mem, pio_enable,
    input  mem_rdata, algo_done,
    output mem_sel, mem_addr, mem_wdata, mem_we, algo_start, algo_op,
    output stat_busy, stat_done, stat_error, stat_rdata
  );
endinterface

// File: rtl/hps_cmd_sequencer_pio_sync.sv
// N-stage synchroniser for the PIO operand bus and enable, with a rising-edge detect on enable.
module pio_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             en_sync,
  output logic             en_rise
);
  logic [WIDTH:0] chain_reg [STAGES];
  logic           en_prev_reg;

  // Enable travels with the operands so both arrive on the same cycle.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) chain_reg[gi] <= '0;
          else        chain_reg[gi] <= {en, d};
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) chain_reg[gi] <= '0;
          else        chain_reg[gi] <= chain_reg[gi-1];
        end
      end
    end
  endgenerate

  assign {en_sync, q} = chain_reg[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_prev_reg <= 1'b0;
    else        en_prev_reg <= en_sync;
  end

  assign en_rise = en_sync & ~en_prev_reg;
endmodule

// File: rtl/hps_cmd_sequencer.sv
// HPS command sequencer: PIO command -> frame-memory / engine operation -> status PIOs.
// Optional engine watchdog enabled by defining HPS_CMD_TIMEOUT_EN.
module hps_cmd_sequencer
  import hps_cmd_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef HPS_CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input logic               clk_clk,
  input logic               reset_reset_n,
  hps_cmd_sequencer_if.slave bus
);
  localparam int SYNC_W = OPCODE_W + DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  logic [SYNC_W-1:0] pio_bus, pio_synced;
  logic              en_sync, en_rise;

  assign pio_bus = {bus.pio_instruction, bus.pio_data, bus.pio_mem_addr, bus.pio_sel_mem};

  pio_sync #(.WIDTH(SYNC_W), .STAGES(SYNC_STAGES)) u_pio_sync (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .d       (pio_bus),
    .en      (bus.pio_enable),
    .q       (pio_synced),
    .en_sync (en_sync),
    .en_rise (en_rise)
  );

  state_e              state_reg;
  logic [OPCODE_W-1:0] op_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                sel_reg;
  logic                mem_sel_reg, mem_we_reg, algo_start_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg, stat_rdata_reg;
  logic [1:0]          algo_op_reg;
  logic                stat_busy_reg, stat_done_reg, stat_error_reg;
`ifdef HPS_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]     timeout_cnt_reg;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg      <= ST_IDLE;
      op_reg         <= '0;
      data_reg       <= '0;
      addr_reg       <= '0;
      sel_reg        <= 1'b0;
      mem_sel_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_we_reg     <= 1'b0;
      algo_start_reg <= 1'b0;
      algo_op_reg    <= '0;
      stat_busy_reg  <= 1'b0;
      stat_done_reg  <= 1'b0;
      stat_error_reg <= 1'b0;
      stat_rdata_reg <= '0;
`ifdef HPS_CMD_TIMEOUT_EN
      timeout_cnt_reg <= '0;
`endif
    end else begin
      mem_we_reg     <= 1'b0;
      algo_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (en_rise) begin
            op_reg        <= pio_synced[SYNC_W-1 -: OPCODE_W];
            data_reg      <= pio_synced[ADDR_W+DATA_W:ADDR_W+1];
            addr_reg      <= pio_synced[ADDR_W:1];
            sel_reg       <= pio_synced[0];
            stat_busy_reg <= 1'b1;
            state_reg     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          stat_error_reg <= 1'b0;
          mem_sel_reg    <= sel_reg;
          mem_addr_reg   <= addr_reg;
          mem_wdata_reg  <= data_reg;
          if (is_mem_op(opcode_e'(op_reg)) && ({1'b0, addr_reg} >= DEPTH_X)) begin
            stat_error_reg <= 1'b1;
            stat_busy_reg  <= 1'b0;
            stat_done_reg  <= 1'b1;
            state_reg      <= ST_DONE;
          end else begin
            case (opcode_e'(op_reg))
              OP_NOP: begin
                stat_busy_reg <= 1'b0;
                stat_done_reg <= 1'b1;
                state_reg     <= ST_DONE;
              end
              OP_WRITE: begin
                mem_we_reg <= 1'b1;
                state_reg  <= ST_WRITE;
              end
              OP_READ: state_reg <= ST_RD_ADDR;
              OP_FILL: begin
                mem_we_reg <= 1'b1;
                state_reg  <= ST_FILL;
              end
              default: begin
                algo_start_reg <= 1'b1;
                algo_op_reg    <= op_reg[1:0];
                state_reg      <= ST_ALGO_START;
`ifdef HPS_CMD_TIMEOUT_EN
                timeout_cnt_reg <= '0;
`endif
              end
            endcase
          end
        end
        ST_WRITE, ST_RD_WAIT: begin
          if (state_reg == ST_RD_WAIT) stat_rdata_reg <= bus.mem_rdata;
          stat_busy_reg <= 1'b0;
          stat_done_reg <= 1'b1;
          state_reg     <= ST_DONE;
        end
        ST_RD_ADDR: state_reg <= ST_RD_WAIT;
        ST_FILL: begin
          // The word at mem_addr is written this cycle; stop at the last address, never wrap.
          if (mem_addr_reg == LAST_ADDR) begin
            stat_busy_reg <= 1'b0;
            stat_done_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end else begin
            mem_we_reg   <= 1'b1;
            mem_addr_reg <= mem_addr_reg + ADDR_W'(1);
          end
        end
        ST_ALGO_START: state_reg <= ST_ALGO_WAIT;
        ST_ALGO_WAIT: begin
          if (bus.algo_done) begin
            stat_busy_reg <= 1'b0;
            stat_done_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
`ifdef HPS_CMD_TIMEOUT_EN
          else if (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
            stat_error_reg <= 1'b1;
            stat_busy_reg  <= 1'b0;
            stat_done_reg  <= 1'b1;
            state_reg      <= ST_DONE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
          end
`endif
        end
        ST_DONE: begin
          if (!en_sync) begin
            stat_done_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
      // A new strobe while a command is still owned is a protocol violation; it overrides the DECODE clear.
      if (en_rise && (state_reg != ST_IDLE)) stat_error_reg <= 1'b1;
    end
  end

  assign bus.mem_sel    = mem_sel_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.mem_we     = mem_we_reg;
  assign bus.algo_start = algo_start_reg;
  assign bus.algo_op    = algo_op_reg;
  assign bus.stat_busy  = stat_busy_reg;
  assign bus.stat_done  = stat_done_reg;
  assign bus.stat_error = stat_error_reg;
  assign bus.stat_rdata = stat_rdata_reg;
endmodule

// File: tb/tb_hps_cmd_sequencer.sv
// Scoreboard bench for hps_cmd_sequencer: stimulus pushes expectations, a negedge monitor checks them.
module tb_hps_cmd_sequencer;
  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 76800;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hps_cmd_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  hps_cmd_sequencer #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MEM_DEPTH   (MEM_DEPTH),
    .SYNC_STAGES (2)
`ifdef HPS_CMD_TIMEOUT_EN
    , .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  typedef struct packed {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] rdata;
    int                busy;   // expected busy cycles, -1 = not checked
  } done_t;

  wr_t        exp_wr_q[$];
  done_t      exp_done_q[$];
  logic [1:0] exp_algo_q[$];

  int   tests = 0;
  int   fails = 0;
  bit   engine_on = 1'b1;
  logic prev_done = 1'b0;
  logic prev_start = 1'b0;
  int   busy_cnt = 0;

  logic [DATA_W-1:0] mem_model [2][MEM_DEPTH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Frame memory: registered read, one cycle after address.
  always @(posedge clk) begin
    if (bus.mem_we && (int'(bus.mem_addr) < MEM_DEPTH))
      mem_model[bus.mem_sel][bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= (int'(bus.mem_addr) < MEM_DEPTH) ? mem_model[bus.mem_sel][bus.mem_addr] : '0;
  end

  // Engine: completes 50 cycles after each start pulse unless disabled.
  initial begin
    bus.algo_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.algo_start && engine_on) begin
        repeat (50) @(negedge clk);
        bus.algo_done = 1'b1;
        @(negedge clk);
        bus.algo_done = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    wr_t   w;
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("we_during_reset", 32'(bus.mem_we), 32'd0);
        busy_cnt   = 0;
        prev_done  = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (bus.stat_busy) busy_cnt++;
        if (bus.mem_we) begin
          if (exp_wr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got sel=%0d addr=%0d data=0x%0h, required no write",
                     bus.mem_sel, bus.mem_addr, bus.mem_wdata);
          end else begin
            w = exp_wr_q.pop_front();
            check("write", 32'({bus.mem_sel, bus.mem_addr, bus.mem_wdata}), 32'(w));
          end
        end
        if (bus.algo_start && prev_start) begin
          tests++; fails++;
          $display("FAIL algo_start_width: got high 2+ cycles, required 1");
        end else if (bus.algo_start) begin
          if (exp_algo_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_algo_start: got op=%0d, required none", bus.algo_op);
          end else begin
            check("algo_op", 32'(bus.algo_op), 32'(exp_algo_q.pop_front()));
          end
        end
        if (bus.stat_done && !prev_done) begin
          if (exp_done_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: got done=1, required none");
          end else begin
            d = exp_done_q.pop_front();
            check("done_error", 32'(bus.stat_error), 32'(d.err));
            check("done_rdata", 32'(bus.stat_rdata), 32'(d.rdata));
            if (d.busy >= 0) check("busy_cycles", 32'(busy_cnt), 32'(d.busy));
          end
          busy_cnt = 0;
        end
        prev_done  = bus.stat_done;
        prev_start = bus.algo_start;
      end
    end
  end

  task automatic push_done(input logic err, input logic [DATA_W-1:0] rdata, input int busy);
    done_t d;
    d.err = err; d.rdata = rdata; d.busy = busy;
    exp_done_q.push_back(d);
  endtask

  task automatic push_writes(input int first, input int last, input logic sel, input logic [DATA_W-1:0] data);
    for (int a = first; a <= last; a++) exp_wr_q.push_back({sel, ADDR_W'(a), data});
  endtask

  task automatic start_cmd(input logic [2:0] op, input int addr, input logic [DATA_W-1:0] data, input logic sel);
    @(negedge clk);
    bus.pio_instruction = op;
    bus.pio_mem_addr    = ADDR_W'(addr);
    bus.pio_data        = data;
    bus.pio_sel_mem     = sel;
    bus.pio_enable      = 1'b1;
    $display("[TB] cmd op=%0d addr=%0d data=0x%0h sel=%0d", op, addr, data, sel);
  endtask

  task automatic finish_cmd();
    int n = 0;
    while (!bus.stat_done && n < 3000) begin @(negedge clk); n++; end
    if (!bus.stat_done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, required done=1", n);
    end
    @(negedge clk);
    bus.pio_enable = 1'b0;
    n = 0;
    while (bus.stat_done && n < 20) begin @(negedge clk); n++; end
    if (bus.stat_done) begin
      tests++; fails++;
      $display("FAIL done_release: got done=1 after enable low, required 0");
    end
  endtask

  initial begin
    bus.pio_instruction = '0;
    bus.pio_data        = '0;
    bus.pio_mem_addr    = '0;
    bus.pio_sel_mem     = 1'b0;
    bus.pio_enable      = 1'b0;
    rst_n               = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_we",     32'(bus.mem_we),     32'd0);
    check("rst_mem_sel",    32'(bus.mem_sel),    32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    check("rst_algo_start", 32'(bus.algo_start), 32'd0);
    check("rst_algo_op",    32'(bus.algo_op),    32'd0);
    check("rst_busy",       32'(bus.stat_busy),  32'd0);
    check("rst_done",       32'(bus.stat_done),  32'd0);
    check("rst_error",      32'(bus.stat_error), 32'd0);
    check("rst_rdata",      32'(bus.stat_rdata), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // WRITE bank1 0x10 = 0xA5, then READ it back
    push_writes(16, 16, 1'b1, 8'hA5);
    push_done(1'b0, 8'h00, 2);
    start_cmd(3'd1, 16, 8'hA5, 1'b1); finish_cmd();
    push_done(1'b0, 8'hA5, 3);
    start_cmd(3'd2, 16, 8'h00, 1'b1); finish_cmd();

    // FILL the last 10 words, then out-of-range WRITE, then NOP clears error
    push_writes(76790, 76799, 1'b0, 8'h3C);
    push_done(1'b0, 8'hA5, 11);
    start_cmd(3'd3, 76790, 8'h3C, 1'b0); finish_cmd();
    push_done(1'b1, 8'hA5, 1);
    start_cmd(3'd1, 76800, 8'h77, 1'b0); finish_cmd();
    push_done(1'b0, 8'hA5, 1);
    start_cmd(3'd0, 0, 8'h00, 1'b0); finish_cmd();

    // ALGO op 5
    exp_algo_q.push_back(2'd1);
    push_done(1'b0, 8'hA5, -1);
    start_cmd(3'd5, 0, 8'h00, 1'b0); finish_cmd();

    // Enable re-strobed mid-FILL: ignored, error set, FILL completes
    push_writes(76700, 76799, 1'b1, 8'h5A);
    push_done(1'b1, 8'hA5, 101);
    start_cmd(3'd3, 76700, 8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    bus.pio_enable = 1'b0;
    repeat (3) @(negedge clk);
    bus.pio_enable = 1'b1;
    finish_cmd();

`ifdef HPS_CMD_TIMEOUT_EN
    engine_on = 1'b0;
    exp_algo_q.push_back(2'd2);
    push_done(1'b1, 8'hA5, 102);
    start_cmd(3'd6, 0, 8'h00, 1'b0); finish_cmd();
    engine_on = 1'b1;
`endif

    // Async reset in the middle of a long FILL
    push_writes(76000, 76799, 1'b0, 8'h11);
    start_cmd(3'd3, 76000, 8'h11, 1'b0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we",    32'(bus.mem_we),     32'd0);
    check("abort_busy",  32'(bus.stat_busy),  32'd0);
    check("abort_done",  32'(bus.stat_done),  32'd0);
    check("abort_error", 32'(bus.stat_error), 32'd0);
    check("abort_rdata", 32'(bus.stat_rdata), 32'd0);
    check("abort_addr",  32'(bus.mem_addr),   32'd0);
    exp_wr_q.delete();
    bus.pio_enable = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Recovery and read-back of earlier writes
    push_done(1'b0, 8'hA5, 3);
    start_cmd(3'd2, 16, 8'h00, 1'b1); finish_cmd();
    push_done(1'b0, 8'h3C, 3);
    start_cmd(3'd2, 76795, 8'h00, 1'b0); finish_cmd();
    push_done(1'b0, 8'h5A, 3);
    start_cmd(3'd2, 76750, 8'h00, 1'b1); finish_cmd();

    repeat (5) @(negedge clk);
    check("wr_q_empty",   32'(exp_wr_q.size()),   32'd0);
    check("done_q_empty", 32'(exp_done_q.size()), 32'd0);
    check("algo_q_empty", 32'(exp_algo_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
